// File: rtl/dcpu16_tmr.sv
// Interval timer on the DCPU16 ab_ data bus: four registers, prescaled down-counter
// with reload, sticky expiry flag and level interrupt.
module dcpu16_tmr #(
    parameter logic [15:0] BASE = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ab_adr,
    input  logic [15:0] ab_dto,
    input  logic        ab_stb,
    input  logic        ab_wre,
    output logic        ab_ack,
    output logic [15:0] ab_dti,
    output logic        irq
);

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_RELOAD = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] OFS_STATUS = 2'd3;

    logic        en, ie, oneshot, expf;
    logic [3:0]  psc_cfg, psc;
    logic [15:0] reload, count;
    logic [15:0] rdata;
    logic        hit, acc, wr, tick, expire;
    logic        wr_ctrl, wr_reload, wr_count, clr_exp;

    assign hit       = ab_stb & (ab_adr[15:2] == BASE[15:2]);
    // ~ab_ack makes a held strobe complete once, then re-arm after one idle cycle
    assign acc       = hit & ~ab_ack;
    assign wr        = acc & ab_wre;
    assign wr_ctrl   = wr & (ab_adr[1:0] == OFS_CTRL);
    assign wr_reload = wr & (ab_adr[1:0] == OFS_RELOAD);
    assign wr_count  = wr & (ab_adr[1:0] == OFS_COUNT);
    assign clr_exp   = wr & (ab_adr[1:0] == OFS_STATUS) & ab_dto[0];

    assign tick   = en & (psc == psc_cfg);
    assign expire = tick & (count == 16'h0000);
    assign irq    = expf & ie;

    always_comb begin
        rdata = 16'h0000;
        case (ab_adr[1:0])
            OFS_CTRL:   rdata = {4'h0, psc_cfg, 5'h00, oneshot, ie, en};
            OFS_RELOAD: rdata = reload;
            OFS_COUNT:  rdata = count;
            OFS_STATUS: rdata = {15'h0000, expf};
            default:    rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ab_ack  <= 1'b0;
            ab_dti  <= 16'h0000;
            en      <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
            psc_cfg <= 4'h0;
            psc     <= 4'h0;
            reload  <= 16'h0000;
            count   <= 16'h0000;
            expf    <= 1'b0;
        end else begin
            ab_ack <= acc;
            ab_dti <= (acc & ~ab_wre) ? rdata : 16'h0000;

            if (!en || tick) psc <= 4'h0;
            else             psc <= psc + 4'h1;

            // A bus write to CTRL overrides the oneshot auto-disable on the same edge
            if (wr_ctrl) begin
                en      <= ab_dto[0];
                ie      <= ab_dto[1];
                oneshot <= ab_dto[2];
                psc_cfg <= ab_dto[11:8];
            end else if (expire && oneshot) begin
                en <= 1'b0;
            end

            if (wr_reload) reload <= ab_dto;

            if (wr_count)    count <= ab_dto;
            else if (expire) count <= reload;
            else if (tick)   count <= count - 16'h0001;

            // Set beats clear so a coincident expiry is never lost
            expf <= expire | (expf & ~clr_exp);
        end
    end

endmodule

// File: tb/tb_dcpu16_tmr.sv
// Directed bench for dcpu16_tmr: register access, decode, periodic and oneshot
// expiry, same-edge collisions and asynchronous reset during an access.
module tb_dcpu16_tmr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ab_adr = 16'h0000;
    logic [15:0] ab_dto = 16'h0000;
    logic        ab_stb = 1'b0;
    logic        ab_wre = 1'b0;
    logic        ab_ack;
    logic [15:0] ab_dti;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0, t1, t2;
    logic [15:0] q;

    localparam logic [15:0] A_CTRL   = 16'h8000;
    localparam logic [15:0] A_RELOAD = 16'h8001;
    localparam logic [15:0] A_COUNT  = 16'h8002;
    localparam logic [15:0] A_STATUS = 16'h8003;

    dcpu16_tmr #(.BASE(16'h8000)) dut (
        .clk    (clk),
        .rst    (rst),
        .ab_adr (ab_adr),
        .ab_dto (ab_dto),
        .ab_stb (ab_stb),
        .ab_wre (ab_wre),
        .ab_ack (ab_ack),
        .ab_dti (ab_dti),
        .irq    (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at edge index cyc (+1ns); the access's ack edge is then cyc+1.
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; ack edge is the first posedge, returns 1ns after the next one.
    task automatic bus(input logic w, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd);
        @(negedge clk);
        ab_stb = 1'b1; ab_wre = w; ab_adr = a; ab_dto = d;
        @(posedge clk); #1;
        chk("ack_hi", {15'h0, ab_ack}, 16'h1);
        rd = ab_dti;
        ab_stb = 1'b0; ab_wre = 1'b0;
        @(posedge clk); #1;
        chk("ack_lo", {15'h0, ab_ack}, 16'h0);
        chk("dti_idle", ab_dti, 16'h0000);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ack", {15'h0, ab_ack}, 16'h0);
        chk("rst_dti", ab_dti, 16'h0000);
        chk("rst_irq", {15'h0, irq}, 16'h0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, A_CTRL + 16'(i), 16'h0000, q);
            chk("rst_reg", q, 16'h0000);
        end
        bus(1'b1, A_RELOAD, 16'hBEEF, q);
        bus(1'b0, A_RELOAD, 16'h0000, q);
        chk("reload_rb", q, 16'hBEEF);

        // Address decode: out-of-window writes must be ignored
        @(negedge clk);
        ab_stb = 1'b1; ab_wre = 1'b1; ab_adr = 16'h8004; ab_dto = 16'hFFFF;
        repeat (3) begin @(posedge clk); #1; chk("nohit_8004", {15'h0, ab_ack}, 16'h0); end
        ab_adr = 16'h7FFF;
        repeat (3) begin @(posedge clk); #1; chk("nohit_7fff", {15'h0, ab_ack}, 16'h0); end
        ab_stb = 1'b0; ab_wre = 1'b0;
        bus(1'b0, A_CTRL, 16'h0, q);   chk("nohit_ctrl", q, 16'h0000);
        bus(1'b0, A_RELOAD, 16'h0, q); chk("nohit_reload", q, 16'hBEEF);
        bus(1'b0, A_COUNT, 16'h0, q);  chk("nohit_count", q, 16'h0000);
        bus(1'b0, A_STATUS, 16'h0, q); chk("nohit_status", q, 16'h0000);

        // Periodic expiry, PSC=0
        bus(1'b1, A_RELOAD, 16'd3, q);
        bus(1'b1, A_COUNT, 16'd3, q);
        bus(1'b1, A_CTRL, 16'h0003, q);
        t0 = cyc - 1;
        for (int i = 2; i <= 4; i++) begin
            goto(t0 + i);
            chk("irq_first", {15'h0, irq}, (i == 4) ? 16'h1 : 16'h0);
        end
        bus(1'b1, A_STATUS, 16'h0001, q);          // ack t0+5
        chk("exp_clr", {15'h0, irq}, 16'h0);
        goto(t0 + 7); chk("irq_gap", {15'h0, irq}, 16'h0);
        goto(t0 + 8); chk("irq_repeat", {15'h0, irq}, 16'h1);
        bus(1'b1, A_STATUS, 16'h0001, q);          // ack t0+9
        chk("exp_clr2", {15'h0, irq}, 16'h0);
        goto(t0 + 11);
        bus(1'b1, A_STATUS, 16'h0001, q);          // ack t0+12, same edge as expiry
        chk("clr_vs_set", {15'h0, irq}, 16'h1);
        bus(1'b0, A_STATUS, 16'h0, q);
        chk("status_set", q, 16'h0001);
        for (int k = 0; k < 5; k++) begin
            goto(t0 + 16 + 5 * k);
            bus(1'b0, A_COUNT, 16'h0, q);
            chk("count_seq", q, (k == 0 || k == 4) ? 16'd3 : 16'(3 - k));
        end

        // Prescale and oneshot
        bus(1'b1, A_CTRL, 16'h0000, q);
        bus(1'b1, A_STATUS, 16'h0001, q);
        bus(1'b1, A_RELOAD, 16'd1, q);
        bus(1'b1, A_COUNT, 16'd1, q);
        bus(1'b1, A_CTRL, 16'h0205, q);
        t1 = cyc - 1;
        goto(t1 + 5);
        bus(1'b0, A_STATUS, 16'h0, q);             // ack t1+6: pre-edge value
        chk("os_before", q, 16'h0000);
        bus(1'b0, A_STATUS, 16'h0, q);             // ack t1+8
        chk("os_exp", q, 16'h0001);
        bus(1'b0, A_CTRL, 16'h0, q);   chk("os_en_off", q, 16'h0204);
        bus(1'b0, A_COUNT, 16'h0, q);  chk("os_count", q, 16'h0001);
        chk("os_noirq", {15'h0, irq}, 16'h0);
        bus(1'b1, A_STATUS, 16'h0001, q);
        goto(cyc + 20);
        bus(1'b0, A_STATUS, 16'h0, q); chk("os_no_more", q, 16'h0000);
        bus(1'b0, A_COUNT, 16'h0, q);  chk("os_hold", q, 16'h0001);

        // COUNT write on a tick edge, PSC=2
        bus(1'b1, A_CTRL, 16'h0201, q);
        t2 = cyc - 1;
        goto(t2 + 2);
        bus(1'b1, A_COUNT, 16'h0010, q);           // ack t2+3 = tick edge
        bus(1'b0, A_COUNT, 16'h0, q);              // ack t2+5
        chk("cnt_wr_wins", q, 16'h0010);
        bus(1'b0, A_COUNT, 16'h0, q);              // ack t2+7, after tick at t2+6
        chk("cnt_next_tick", q, 16'h000F);

        // Reset while an access is acknowledged and the timer runs
        bus(1'b1, A_CTRL, 16'h0003, q);
        goto(cyc + 20);
        chk("irq_run", {15'h0, irq}, 16'h1);
        @(negedge clk);
        ab_stb = 1'b1; ab_wre = 1'b0; ab_adr = A_COUNT;
        @(posedge clk); #1;
        chk("mid_ack", {15'h0, ab_ack}, 16'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst_ack", {15'h0, ab_ack}, 16'h0);
        chk("arst_irq", {15'h0, irq}, 16'h0);
        chk("arst_dti", ab_dti, 16'h0000);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("held_ack", {15'h0, ab_ack}, 16'h1);
        chk("held_count", ab_dti, 16'h0000);
        ab_stb = 1'b0;
        @(posedge clk); #1;
        chk("held_ack_lo", {15'h0, ab_ack}, 16'h0);
        bus(1'b0, A_CTRL, 16'h0, q);   chk("arst_ctrl", q, 16'h0000);
        bus(1'b0, A_RELOAD, 16'h0, q); chk("arst_reload", q, 16'h0000);
        bus(1'b0, A_STATUS, 16'h0, q); chk("arst_status", q, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcpu16_tmr.md
# dcpu16_tmr

Memory-mapped interval timer that acts as a responder on the DCPU16 `ab_` data bus. The CPU is the initiator (drives stb/wre/adr/dto); this block decodes its address window, returns `ab_ack`, serves reads and writes of four 16-bit registers, and raises a level interrupt on counter expiry. It sits beside the data-port SRAM on the same `ab_` bus; the two have disjoint address windows.

## Interface
- `BASE`, 16'h8000: base address of the 4-word window; bits [1:0] must be 0.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ab_adr`  in  16  word address from CPU.
- `ab_dto`  in  16  write data from CPU.
- `ab_stb`  in  1  bus strobe; held by the CPU until `ab_ack` is seen.
- `ab_wre`  in  1  1 = write, 0 = read; valid with `ab_stb`.
- `ab_ack`  out  1  single-cycle acknowledge.
- `ab_dti`  out  16  read data to CPU; valid only while `ab_ack`=1.
- `irq`  out  1  level interrupt, `STATUS.EXP & CTRL.IE`.

## Operation
- Hit: `ab_stb & (ab_adr[15:2] == BASE[15:2])`. No hit means no response: `ab_ack` stays 0 and no state changes.
- Register map (offset = `ab_adr[1:0]`):
  - 0 CTRL: bit0 EN, bit1 IE, bit2 ONESHOT, bits[11:8] PSC. All other bits read 0 and are ignored on write.
  - 1 RELOAD: 16-bit reload value, read/write.
  - 2 COUNT: reads the live counter; a write loads the counter directly.
  - 3 STATUS: bit0 EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect. Other bits read 0.
- Prescaler: 4-bit counter `psc`, held at 0 whenever EN=0.
  - While EN=1 it counts 0..PSC and wraps.
  - A `tick` is generated when `psc==PSC` and EN=1, so one tick occurs every PSC+1 enabled cycles. PSC=0 gives a tick every cycle.
- On a tick:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: COUNT <= RELOAD and EXP <= 1. If ONESHOT=1, EN <= 0 in the same cycle.
- COUNT decrements modulo 2^16 only through the rule above and never wraps below 0. With RELOAD=N, the expiry period is (N+1)·(PSC+1) cycles.
- Simultaneous events:
  - Bus write to COUNT and a tick in the same cycle: the write wins and that tick is lost.
  - Write-1 clear of EXP and an expiry in the same cycle: the set wins, so EXP stays 1.
  - Write to CTRL and a ONESHOT auto-clear of EN in the same cycle: the bus write wins.
  - A write to CTRL with EN=0 clears `psc` on the following cycle.
- Reads return register values as they were before the edge on which `ab_ack` rises. Write data from that same access is not visible in the read.

## Timing
- Acknowledge: `ab_ack <= hit & ~ab_ack`, registered.
  - For a held strobe, `ab_ack` is high in the cycle after `ab_stb` is first sampled, then low for one cycle.
  - Back-to-back accesses therefore complete at best every 2 cycles.
- The write is committed on the same edge that sets `ab_ack`=1. `ab_dti` is registered on that edge as well.
- `ab_dti` is 0 whenever `ab_ack`=0.
- `irq` is combinational from registers: it rises in the cycle after the expiring tick edge, with no extra latency.
- Reset: the asynchronous, active-low `rst` clears all state immediately.
  - Outputs: `ab_ack`=0, `ab_dti`=0, `irq`=0.
  - Registers: CTRL=0, RELOAD=0, COUNT=0, EXP=0, `psc`=0.
  - Reset asserted mid-access drops `ab_ack` at once. After release, a still-held `ab_stb` is acknowledged as a new access.

## Test plan
- Reset and readback:
  - Stimulus: after reset release, read offsets 0..3.
  - Response: all read 16'h0000; `ab_ack` pulses exactly 1 cycle per access, 1 cycle after `ab_stb`.
  - Stimulus: write RELOAD=16'hBEEF, then read it back.
  - Response: reads 16'hBEEF.
- Address decode:
  - Stimulus: `ab_stb` with `ab_adr`=16'h8004, then 16'h7FFF.
  - Response: `ab_ack` never asserts; all registers unchanged.
- Periodic expiry:
  - Stimulus: RELOAD=3, COUNT=3, CTRL=16'h0003 (EN, IE, PSC=0).
  - Response: EXP and `irq` rise 4 cycles after the CTRL write edge; they repeat every 4 cycles once EXP is cleared; COUNT sequence is 3,2,1,0,3.
- Prescale and oneshot:
  - Stimulus: RELOAD=1, COUNT=1, CTRL=16'h0205 (EN, ONESHOT, PSC=2).
  - Response: expiry after 6 cycles; EN reads 0 afterwards; COUNT holds 1; no further expiry.
- Collisions:
  - Stimulus: a write-1 to STATUS on the same edge as an expiry.
  - Response: EXP remains 1.
  - Stimulus: a COUNT write of 16'h0010 on the same edge as a tick.
  - Response: COUNT reads 16'h0010.
- Reset mid-operation:
  - Stimulus: assert `rst`=0 while `ab_ack`=1 and the timer is running.
  - Response: `ab_ack`, `irq` and COUNT go to 0 without a clock edge. After release, a held `ab_stb` is acknowledged 1 cycle later.
